// File: rtl/order_pkg.sv
// Shared types and helpers for the k2 order-recovery block.
// The recovered order is {MA, d0}, where d0 = (BN - digit sum of MA) mod RADIX.
package order_pkg;

    localparam int DEGREE_W = 16;
    localparam int DELTA    = 4;
    localparam int BANK_W   = 4;
    localparam int RADIX    = 16;
    localparam int MA_W     = DEGREE_W - DELTA;

    typedef logic [MA_W-1:0]            ma_t;
    typedef logic [BANK_W-1:0]          bn_t;
    typedef logic [DEGREE_W-1:0]        order_t;
    typedef logic [$clog2(RADIX)-1:0]   digit_t;

    typedef struct packed {
        ma_t ma;
        bn_t bn;
    } lane_t;

    typedef struct packed {
        order_t     o0;
        order_t     o1;
        logic [2:0] l;
        logic       done;
    } beat_t;

    // Digit add that wraps at the digit width, which is exactly mod RADIX.
    function automatic digit_t digit_sum_mod(input digit_t a, input digit_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/order_recover_fifo.sv
// First-word-fall-through FIFO of beat_t with an occupancy count output.
// When empty, data_o keeps showing the last popped entry.
module order_recover_fifo
    import order_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  beat_t            data_i,
    input  logic             pop_i,
    output beat_t            data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    beat_t            mem_q [DEPTH];
    beat_t            last_d, last_q;
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             pop;

    assign valid_o = (count_q != '0);
    assign pop     = pop_i && valid_o;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            last_d   = mem_q[rd_ptr_q];
        end
        case ({push_i, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments keep all state updates based on pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = valid_o ? mem_q[rd_ptr_q] : last_q;
    assign count_o = count_q;

endmodule

// File: rtl/order_recover_k2.sv
// Rebuilds the two radix-16 order indices from {memory address, bank number} pairs.
// Optional macro ORDER_RECOVER_BANK_CHECK_EN adds a sticky same-bank conflict flag.
module order_recover_k2
    import order_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MA_W-1:0]     MA0_idx,
    input  logic [BANK_W-1:0]   BN0_idx,
    input  logic [MA_W-1:0]     MA1_idx,
    input  logic [BANK_W-1:0]   BN1_idx,
    input  logic [2:0]          l_in,
    input  logic                done_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DEGREE_W-1:0] Order_0,
    output logic [DEGREE_W-1:0] Order_1,
    output logic [2:0]          l_out,
    output logic                done_out
`ifdef ORDER_RECOVER_BANK_CHECK_EN
    ,
    output logic                err_bank_conflict
`endif
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CRED_W = CNT_W + 1;

    logic              accept;
    logic              v1_q, v2_q, v3_q;
    lane_t [1:0]       p1_lane_q, p2_lane_q;
    logic [2:0]        p1_l_q, p2_l_q;
    logic              p1_done_q, p2_done_q;
    digit_t [1:0]      p2_sum_d, p2_sum_q;
    digit_t [1:0]      p3_sum, p3_d0;
    beat_t             p3_beat_d, p3_beat_q;
    beat_t             head;
    logic [CNT_W-1:0]  fifo_count;
    logic [CRED_W-1:0] credits_used;

    // Every beat in flight holds a FIFO slot, so the pipeline never needs to stall.
    assign credits_used = CRED_W'(fifo_count) + CRED_W'(v1_q) + CRED_W'(v2_q) + CRED_W'(v3_q);
    assign in_ready     = credits_used < CRED_W'(FIFO_DEPTH);
    assign accept       = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= accept;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    // Payload registers are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            p1_lane_q[0].ma <= MA0_idx;
            p1_lane_q[0].bn <= BN0_idx;
            p1_lane_q[1].ma <= MA1_idx;
            p1_lane_q[1].bn <= BN1_idx;
            p1_l_q          <= l_in;
            p1_done_q       <= done_in;
        end
        p2_lane_q <= p1_lane_q;
        p2_sum_q  <= p2_sum_d;
        p2_l_q    <= p1_l_q;
        p2_done_q <= p1_done_q;
        p3_beat_q <= p3_beat_d;
    end

    always_comb begin
        p2_sum_d  = '0;
        p3_sum    = '0;
        p3_d0     = '0;
        p3_beat_d = '0;
        for (int i = 0; i < 2; i++) begin
            p2_sum_d[i] = digit_sum_mod(p1_lane_q[i].ma[DELTA-1:0],
                                        p1_lane_q[i].ma[2*DELTA-1:DELTA]);
            p3_sum[i]   = digit_sum_mod(p2_sum_q[i], p2_lane_q[i].ma[3*DELTA-1:2*DELTA]);
            p3_d0[i]    = p2_lane_q[i].bn - p3_sum[i];
        end
        p3_beat_d.o0   = {p2_lane_q[0].ma, p3_d0[0]};
        p3_beat_d.o1   = {p2_lane_q[1].ma, p3_d0[1]};
        p3_beat_d.l    = p2_l_q;
        p3_beat_d.done = p2_done_q;
    end

    order_recover_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (v3_q),
        .data_i  (p3_beat_q),
        .pop_i   (out_ready),
        .data_o  (head),
        .valid_o (out_valid),
        .count_o (fifo_count)
    );

    assign Order_0  = head.o0;
    assign Order_1  = head.o1;
    assign l_out    = head.l;
    assign done_out = head.done;

`ifdef ORDER_RECOVER_BANK_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (v1_q && (p1_lane_q[0].bn == p1_lane_q[1].bn)) begin
            err_q <= 1'b1;
        end
    end

    assign err_bank_conflict = err_q;
`endif

endmodule

// File: tb/tb_order_recover_k2.sv
// Scoreboard bench for order_recover_k2 against a plain-arithmetic reference model.
module tb_order_recover_k2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] MA0_idx, MA1_idx;
    logic [3:0]  BN0_idx, BN1_idx;
    logic [2:0]  l_in;
    logic        done_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Order_0, Order_1;
    logic [2:0]  l_out;
    logic        done_out;
`ifdef ORDER_RECOVER_BANK_CHECK_EN
    logic        err_bank_conflict;
`endif

    order_recover_k2 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .MA0_idx   (MA0_idx),
        .BN0_idx   (BN0_idx),
        .MA1_idx   (MA1_idx),
        .BN1_idx   (BN1_idx),
        .l_in      (l_in),
        .done_in   (done_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Order_0   (Order_0),
        .Order_1   (Order_1),
        .l_out     (l_out),
        .done_out  (done_out)
`ifdef ORDER_RECOVER_BANK_CHECK_EN
        ,
        .err_bank_conflict (err_bank_conflict)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] o0;
        logic [15:0] o1;
        logic [2:0]  l;
        logic        d;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t nx;
    logic rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: order = MA*16 + ((BN - sum of MA's digits) mod 16).
    function automatic logic [15:0] recover_ref(input int ma, input int bn);
        int s;
        int d0;
        s  = (ma % 16) + ((ma / 16) % 16) + ((ma / 256) % 16);
        d0 = (((bn - s) % 16) + 16) % 16;
        return 16'(ma * 16 + d0);
    endfunction

    // Forward rule used to build round-trip stimulus.
    function automatic logic [3:0] bank_of(input int o);
        return 4'(((o % 16) + ((o / 16) % 16) + ((o / 256) % 16) + ((o / 4096) % 16)) % 16);
    endfunction

    task automatic set_inputs(input logic [11:0] ma0, input logic [3:0] bn0,
                              input logic [11:0] ma1, input logic [3:0] bn1,
                              input logic [2:0] l, input logic d,
                              input logic [15:0] e0, input logic [15:0] e1);
        MA0_idx = ma0; BN0_idx = bn0;
        MA1_idx = ma1; BN1_idx = bn1;
        l_in    = l;   done_in = d;
        nx      = '{e0, e1, l, d};
    endtask

    // Presents a beat and returns just after the edge that accepted it; in_valid is left high.
    task automatic drive_beat(input logic [11:0] ma0, input logic [3:0] bn0,
                              input logic [11:0] ma1, input logic [3:0] bn1,
                              input logic [2:0] l, input logic d,
                              input logic [15:0] e0, input logic [15:0] e1,
                              output int waited);
        waited = 0;
        set_inputs(ma0, bn0, ma1, bn1, l, d, e0, e1);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 32'(waited), 32'd200);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] ma0, input logic [3:0] bn0,
                        input logic [11:0] ma1, input logic [3:0] bn1,
                        input logic [2:0] l, input logic d);
        int w;
        drive_beat(ma0, bn0, ma1, bn1, l, d,
                   recover_ref(int'(ma0), int'(bn0)), recover_ref(int'(ma1), int'(bn1)), w);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: records accepted beats and checks every popped / stalled output beat.
    logic stalled = 1'b0;
    exp_t held;
    exp_t e;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(nx);
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_order0", 32'(Order_0), 32'(held.o0));
                check("stall_order1", 32'(Order_1), 32'(held.o1));
                check("stall_l", 32'(l_out), 32'(held.l));
                check("stall_done", 32'(done_out), 32'(held.d));
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("order0", 32'(Order_0), 32'(e.o0));
                        check("order1", 32'(Order_1), 32'(e.o1));
                        check("l_out", 32'(l_out), 32'(e.l));
                        check("done_out", 32'(done_out), 32'(e.d));
                    end
                end else begin
                    stalled = 1'b1;
                    held    = '{Order_0, Order_1, l_out, done_out};
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int stalls;
        int w;
        int o0, o1;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_inputs(12'h0, 4'h0, 12'h0, 4'h0, 3'd0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_order0", 32'(Order_0), 32'd0);
        check("rst_order1", 32'(Order_1), 32'd0);
        check("rst_l_out", 32'(l_out), 32'd0);
        check("rst_done_out", 32'(done_out), 32'd0);
`ifdef ORDER_RECOVER_BANK_CHECK_EN
        check("rst_err", 32'(err_bank_conflict), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Single beat with latency check.
        send(12'h123, 4'h6, 12'hFFF, 4'h0, 3'd3, 1'b0);
        in_valid = 1'b0;
        check("single_ref0", 32'(nx.o0), 32'h1230);
        check("single_ref1", 32'(nx.o1), 32'hFFF3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("latency_not_yet", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check("latency_valid", 32'(out_valid), 32'd1);
        check("latency_order0", 32'(Order_0), 32'h1230);
        check("latency_order1", 32'(Order_1), 32'hFFF3);
        check("latency_l_out", 32'(l_out), 32'd3);
        @(posedge clk);
        #1;
        wait_drain();

        // Wrap-around of the low digit.
        send(12'h000, 4'hF, 12'h111, 4'h2, 3'd5, 1'b1);
        in_valid = 1'b0;
        wait_drain();
        check("wrap_order0", 32'(Order_0), 32'h000F);
        check("wrap_order1", 32'(Order_1), 32'h111F);
        check("empty_hold_valid", 32'(out_valid), 32'd0);

`ifdef ORDER_RECOVER_BANK_CHECK_EN
        check("err_before_conflict", 32'(err_bank_conflict), 32'd0);
        send(12'h321, 4'h5, 12'h654, 4'h5, 3'd1, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("err_at_t", 32'(err_bank_conflict), 32'd0);
        @(negedge clk);
        check("err_at_t1", 32'(err_bank_conflict), 32'd1);
        @(posedge clk);
        #1;
        wait_drain();
`endif

        // Backpressure: 12 beats offered while the consumer stalls.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 24; c++) begin
            if (acc < 12) begin
                set_inputs(12'(acc * 291 + 7), 4'(acc), 12'(acc * 1237), 4'(15 - acc), 3'(acc), 1'(acc % 2),
                           recover_ref((acc * 291 + 7) % 4096, acc % 16),
                           recover_ref((acc * 1237) % 4096, 15 - acc));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd8);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        wait_drain();

        // Randomized traffic with random consumer backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send(12'($urandom), 4'($urandom), 12'($urandom), 4'($urandom),
                 3'($urandom), 1'($urandom));
        end
        in_valid   = 1'b0;
        rand_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        // Reset while 5 beats are buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(12'(i + 40), 4'(i), 12'(i + 80), 4'(i + 3), 3'(i), 1'b0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
`ifdef ORDER_RECOVER_BANK_CHECK_EN
        check("err_sticky", 32'(err_bank_conflict), 32'd1);
`endif
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef ORDER_RECOVER_BANK_CHECK_EN
        check("midrst_err", 32'(err_bank_conflict), 32'd0);
`endif
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_output", 32'(out_valid), 32'd0);

        // Round trip of every order: lane 0 covers the lower half, lane 1 the upper half.
        stalls = 0;
        for (int i = 0; i < 32768; i++) begin
            o0 = i;
            o1 = i + 32768;
            drive_beat(12'(o0 / 16), bank_of(o0), 12'(o1 / 16), bank_of(o1),
                       3'(i), 1'(i == 32767), 16'(o0), 16'(o1), w);
            stalls += w;
        end
        in_valid = 1'b0;
        check("roundtrip_stalls", 32'(stalls), 32'd0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
